// File: rtl/tick_timer_pkg.sv
// rtl/tick_timer_pkg.sv - shared register map and helpers for tick_timer
//
// Purpose : register offsets, CTRL bit positions and byte-lane merge helper,
//           shared with the firmware header generator.
// Ports   : none (package).
package tick_timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_STATUS = 2'd1,
      REG_RELOAD = 2'd2,
      REG_COUNT  = 2'd3
   } reg_sel_e;

   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_IE_BIT = 1;
   localparam int CTRL_AR_BIT = 2;

   localparam logic [15:0] RESET_RELOAD = 16'hFFFF;
   localparam logic [15:0] RESET_COUNT  = 16'hFFFF;

   // Active-low strobes select which byte of wr replaces the same byte of cur.
   function automatic logic [15:0] lane_merge(
      input logic [15:0] cur,
      input logic [15:0] wr,
      input logic        uds_n,
      input logic        lds_n
   );
      return {(uds_n ? cur[15:8] : wr[15:8]), (lds_n ? cur[7:0] : wr[7:0])};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clock divider producing a one-cycle tick every DIV clocks
//
// Purpose : counts 0..DIV-1 while enabled, pulses tick on the wrap to 0.
// Ports   : clk   - system clock
//           reset - synchronous active-high reset
//           en    - count enable; counter held at 0 while low
//           clr   - synchronous clear of the counter
//           tick  - one-cycle pulse, asserted in the cycle the counter wraps
module tick_prescaler #(
   parameter int DIV = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [15:0] r_cnt;
   logic        w_wrap;

   assign w_wrap = (r_cnt == 16'(DIV - 1));
   assign tick   = en && !clr && w_wrap;

   always_ff @(posedge clk) begin
      if (reset || !en || clr) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - bus-mapped down-counting interval timer with interrupt
//
// Purpose : 16-bit down counter clocked by a prescaled tick, one-shot or
//           auto-reload, expiry flag and registered active-low interrupt.
// Ports   : clk      - system clock
//           reset    - synchronous active-high reset
//           cs       - chip select, held for the whole bus cycle
//           rw_n     - 1 = read, 0 = write
//           uds_n    - upper byte strobe (active low)
//           lds_n    - lower byte strobe (active low)
//           addr     - register select
//           data_in  - write data
//           data_out - registered read data (0 when not selected for read)
//           irq_n    - registered interrupt request, !(EXP & IE)
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int PRESCALE = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        rw_n,
   input  logic        uds_n,
   input  logic        lds_n,
   input  logic [1:0]  addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        irq_n
);

   logic        r_en;
   logic        r_ie;
   logic        r_ar;
   logic        r_exp;
   logic [15:0] r_reload;
   logic [15:0] r_count;
   logic [15:0] r_data_out;
   logic        r_irq_n;
   logic        r_wr_d;
   logic        r_wr_blk;

   reg_sel_e    w_sel;
   logic        w_wr;
   logic        w_commit;
   logic        w_any_lane;
   logic        w_ctrl_wr;
   logic        w_stat_wr;
   logic        w_reload_wr;
   logic        w_count_wr;
   logic        w_tick;
   logic        w_expire;
   logic        w_pre_clr;
   logic [15:0] w_rd_data;

   assign w_sel      = reg_sel_e'(addr);
   assign w_wr       = cs && !rw_n;
   // r_wr_blk holds off a write that was already asserted when reset
   // released; only a fresh rising edge of cs&!rw_n may commit.
   assign w_commit   = w_wr && !r_wr_d && !r_wr_blk;
   assign w_any_lane = !(uds_n && lds_n);

   assign w_ctrl_wr   = w_commit && (w_sel == REG_CTRL)   && !lds_n;
   assign w_stat_wr   = w_commit && (w_sel == REG_STATUS) && !lds_n;
   assign w_reload_wr = w_commit && (w_sel == REG_RELOAD) && w_any_lane;
   assign w_count_wr  = w_commit && (w_sel == REG_COUNT)  && w_any_lane;

   // A COUNT write on a tick edge swallows that tick entirely.
   assign w_expire  = w_tick && !w_count_wr && (r_count == 16'd0);
   assign w_pre_clr = w_ctrl_wr && data_in[CTRL_EN_BIT] && !r_en;

   tick_prescaler #(
      .DIV (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (r_en),
      .clr   (w_pre_clr),
      .tick  (w_tick)
   );

   always_comb begin
      w_rd_data = '0;
      case (w_sel)
         REG_CTRL: begin
            w_rd_data[CTRL_EN_BIT] = r_en;
            w_rd_data[CTRL_IE_BIT] = r_ie;
            w_rd_data[CTRL_AR_BIT] = r_ar;
         end
         REG_STATUS: w_rd_data[0] = r_exp;
         REG_RELOAD: w_rd_data = r_reload;
         REG_COUNT:  w_rd_data = r_count;
         default:    w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_en       <= 1'b0;
         r_ie       <= 1'b0;
         r_ar       <= 1'b0;
         r_exp      <= 1'b0;
         r_reload   <= RESET_RELOAD;
         r_count    <= RESET_COUNT;
         r_data_out <= '0;
         r_irq_n    <= 1'b1;
         r_wr_d     <= 1'b0;
         r_wr_blk   <= 1'b1;
      end else begin
         r_wr_d <= w_wr;
         if (!w_wr) begin
            r_wr_blk <= 1'b0;
         end

         // CPU write beats the one-shot auto-disable.
         if (w_ctrl_wr) begin
            r_en <= data_in[CTRL_EN_BIT];
            r_ie <= data_in[CTRL_IE_BIT];
            r_ar <= data_in[CTRL_AR_BIT];
         end else if (w_expire && !r_ar) begin
            r_en <= 1'b0;
         end

         // Expiry beats a simultaneous write-1-to-clear.
         if (w_expire) begin
            r_exp <= 1'b1;
         end else if (w_stat_wr && data_in[0]) begin
            r_exp <= 1'b0;
         end

         if (w_reload_wr) begin
            r_reload <= lane_merge(r_reload, data_in, uds_n, lds_n);
         end

         if (w_count_wr) begin
            r_count <= lane_merge(r_count, data_in, uds_n, lds_n);
         end else if (w_tick) begin
            r_count <= (r_count == 16'd0) ? r_reload : (r_count - 16'd1);
         end

         r_irq_n    <= !(r_exp && r_ie);
         r_data_out <= (cs && rw_n) ? w_rd_data : 16'd0;
      end
   end

   assign data_out = r_data_out;
   assign irq_n    = r_irq_n;

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 PRESCALE, 25, clk cycles per timer tick (25 gives 1 us at 25 MHz); legal range 1..65535.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cs  input  1  chip select, decoded by the system from the CPU address bus; held for the whole bus cycle.
REQ-005 rw_n  input  1  1 = read, 0 = write.
REQ-006 uds_n  input  1  active-low upper byte strobe, gates data_in[15:8].
REQ-007 lds_n  input  1  active-low lower byte strobe, gates data_in[7:0].
REQ-008 addr  input  2  register select (CPU address bits 2:1).
REQ-009 data_in  input  16  write data from the CPU.
REQ-010 data_out  output  16  registered read data.
REQ-011 irq_n  output  1  active-low interrupt request, feeds the CPU IPL encoder.

Function
REQ-012 Register map by addr:
- 0 = CTRL: bit0 EN, bit1 IE, bit2 AR (auto-reload); bits 15:3 read 0.
- 1 = STATUS: bit0 EXP; write 1 to clear.
- 2 = RELOAD: 16 bits.
- 3 = COUNT: 16 bits; read returns the live value, write loads it.
REQ-013 Each bus cycle commits exactly one write, in the first clk cycle where cs=1 and rw_n=0 (rising-edge detect on cs&!rw_n); further cycles of the same bus cycle have no effect.
REQ-014 Byte lanes:
- uds_n=0 updates bits 15:8; lds_n=0 updates bits 7:0.
- Both strobes high: no register changes.
- CTRL and STATUS use only the low byte.
REQ-015 data_out is valid one clk after cs=1 with rw_n=1, reflecting the register state at that edge; it is 0 whenever cs was 0 in the previous cycle.
REQ-016 Prescaler:
- Counts 0..PRESCALE-1 while EN=1 and emits a one-cycle tick when it wraps to 0.
- Held at 0 while EN=0.
- Cleared when EN is written 0->1.
REQ-017 On each tick:
- COUNT=0: EXP<=1, COUNT<=RELOAD, and EN<=0 if AR=0.
- COUNT>0: COUNT<=COUNT-1.
- Period is therefore RELOAD+1 ticks.
REQ-018 A CPU write to COUNT in the same cycle as a tick takes priority; that tick's decrement and expiry are discarded.
REQ-019 A STATUS clear in the same cycle as an expiry leaves EXP=1 (set wins).
REQ-020 A write to CTRL in the same cycle as a one-shot auto-disable wins: EN takes the written value.
REQ-021 irq_n is registered and equals !(EXP & IE) with one clk of latency; clearing IE deasserts it without clearing EXP.
REQ-022 COUNT wraps nowhere: decrement below 0 never occurs (expiry reloads instead).
REQ-023 PRESCALE=1 gives one tick per clk while EN=1.

Reset
REQ-024 On reset=1 at a clk edge:
- CTRL=0, EXP=0, RELOAD=0xFFFF, COUNT=0xFFFF, prescaler=0.
- data_out=0, irq_n=1, write edge detector cleared.
REQ-025 Reset mid-count or mid-bus-cycle aborts all activity. A cs/write still asserted when reset releases does not commit; only a fresh cs&!rw_n edge does.

Structure
REQ-026 Register offsets (CTRL=0, STATUS=1, RELOAD=2, COUNT=3) and CTRL bit positions are constants in the shared system package, which the firmware header generator also consumes.
REQ-027 The prescaler is a separate sub-module, tick_prescaler (parameter DIV; inputs clk, reset, en, clr; output tick), reusable for the baud clock.
REQ-028 The block contains no combinational path from bus inputs to data_out or irq_n.

Verification
REQ-029 Bench covers the following scenarios:
- One-shot: PRESCALE=4, RELOAD=3, COUNT=3, CTRL=0x3 -> irq_n falls 17 clks after the CTRL write commits (16 clks to the expiring tick plus 1 registered irq_n); EN reads 0; COUNT reads 3.
- Auto-reload: RELOAD=1, COUNT=1, CTRL=0x7, PRESCALE=1 -> EXP sets every 2 clks. Writing STATUS=1 coincident with an expiry leaves EXP=1.
- Byte lanes: write COUNT=0xABCD with only uds_n low over COUNT=0xFFFF, EN=0 -> reads 0xABFF.
- Held write: cs&!rw_n held 5 clks writing COUNT=0x0010 while ticking every clk -> COUNT reads 0x0010 minus ticks since the first cycle, not reloaded each cycle.
- Collision: COUNT write of 0x0005 on a tick edge with COUNT=0 -> COUNT=0x0005, EXP unchanged.
- Reset mid-count: reset pulse with COUNT=0x0042, EN=1, irq_n=0 -> next clk all registers at reset values, irq_n=1, data_out=0.
